// File: rtl/req_gnt_sched_pkg.sv
// rtl/req_gnt_sched_pkg.sv - shared types and constants for the req/gnt round-robin scheduler
//
// Purpose: FSM state encoding, hold counter width and default parameter
// values used by req_gnt_sched and its testbench.
// Ports: none (package).
// Build option: none here; the top honours `REQ_GNT_SCHED_ERR_EN.

package req_gnt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GRANT,
    HOLD
  } sched_state_t;

  // Hold counter width; covers HOLD_CYCLES up to 255.
  localparam int HOLD_CNT_W = 8;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/req_gnt_sched_if.sv
// rtl/req_gnt_sched_if.sv - requester-side bundle of the req/gnt scheduler
//
// Purpose: groups the per-requester handshake vectors and the shared
// status outputs so the scheduler and its requesters connect through one port.
// Signals:
//   want  [NUM_REQ]  level, requester i wants the resource
//   req   [NUM_REQ]  one-cycle request pulse, honoured only on the open slot
//   slot  [NUM_REQ]  one-hot offer, zero when no offer is open
//   gnt   [NUM_REQ]  one-hot one-cycle grant pulse
//   busy             resource occupied (GRANT or HOLD)
//   owner [log2 N]   index of the current or last granted requester
// Modports: master = requester side, slave = scheduler side.

interface req_gnt_sched_if #(
  parameter int NUM_REQ = 4
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] want;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] slot;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic [IW-1:0]      owner;

  modport master (
    output want,
    output req,
    input  slot,
    input  gnt,
    input  busy,
    input  owner
  );

  modport slave (
    input  want,
    input  req,
    output slot,
    output gnt,
    output busy,
    output owner
  );

endinterface

// File: rtl/req_gnt_sched_rr_pick.sv
// rtl/req_gnt_sched_rr_pick.sv - combinational round-robin picker
//
// Purpose: selects the first set bit of want at or after ptr, wrapping
// past NUM_REQ-1 back to 0. NUM_REQ need not be a power of two.
// Ports:
//   want  in  [NUM_REQ]  candidate requesters
//   ptr   in  [log2 N]   starting index of the search (0..NUM_REQ-1)
//   valid out 1          at least one want bit is set
//   idx   out [log2 N]   selected requester index (0 when valid is low)

module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         want,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int DW = 2 * NUM_REQ;

  logic [DW-1:0] dbl;
  logic [DW-1:0] masked;
  int            sel;

  // Duplicating want turns the wrapping search into a plain lowest-set-bit
  // search over positions >= ptr; a hit in the upper copy maps back by -N.
  assign dbl   = {want, want};
  assign valid = |want;

  always_comb begin
    masked = '0;
    for (int j = 0; j < DW; j++) begin
      masked[j] = dbl[j] && (j >= int'(ptr));
    end
  end

  always_comb begin
    sel = 0;
    for (int j = DW - 1; j >= 0; j--) begin
      if (masked[j]) begin
        sel = j;
      end
    end
  end

  always_comb begin
    idx = '0;
    if (valid) begin
      if (sel >= NUM_REQ) begin
        idx = IW'(sel - NUM_REQ);
      end else begin
        idx = IW'(sel);
      end
    end
  end

endmodule

// File: rtl/req_gnt_sched.sv
// rtl/req_gnt_sched.sv - round-robin scheduler sharing one resource over req/gnt
//
// Purpose: offers a single downstream resource to NUM_REQ requesters in
// round-robin order. A wanting requester gets a one-hot slot, pulses req
// while it holds the slot, receives gnt one cycle later, and the resource
// then stays occupied for HOLD_CYCLES cycles.
// Parameters: NUM_REQ (2..16), HOLD_CYCLES (1..255).
// Ports:
//   clk      in   single clock
//   reset    in   synchronous, active-high
//   bus      slave modport of req_gnt_sched_if (want/req in, slot/gnt/busy/owner out)
//   err      out  sticky stray-request flag        (only with REQ_GNT_SCHED_ERR_EN)
//   err_cnt  out  saturating stray-request count   (only with REQ_GNT_SCHED_ERR_EN)
// Build option: define REQ_GNT_SCHED_ERR_EN to build the stray-request monitor.

module req_gnt_sched
  import req_gnt_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  req_gnt_sched_if.slave bus
`ifdef REQ_GNT_SCHED_ERR_EN
  ,
  output logic           err,
  output logic [7:0]     err_cnt
`endif
);

  localparam int                    IW        = $clog2(NUM_REQ);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

  sched_state_t          state_q;
  sched_state_t          state_d;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         ptr_d;
  logic [IW-1:0]         owner_q;
  logic [IW-1:0]         owner_d;
  logic [HOLD_CNT_W-1:0] cnt_q;
  logic [HOLD_CNT_W-1:0] cnt_d;

  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    owner_oh;
  logic [IW-1:0]         owner_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .want  (bus.want),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_oh = {{(NUM_REQ - 1){1'b0}}, 1'b1} << owner_q;

  // Explicit wrap so a non-power-of-two NUM_REQ never leaves ptr out of range.
  assign owner_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // req is checked first so a simultaneous want drop still grants.
        if (bus.req[owner_q]) begin
          state_d = GRANT;
        end else if (!bus.want[owner_q]) begin
          state_d = IDLE;
          ptr_d   = owner_next;
        end
      end
      GRANT: begin
        cnt_d   = HOLD_LOAD;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ptr_d   = owner_next;
        end else begin
          cnt_d = cnt_q - HOLD_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output
  // combinationally and reset clears everything at the next edge.
  assign bus.slot  = (state_q == OFFER) ? owner_oh : '0;
  assign bus.gnt   = (state_q == GRANT) ? owner_oh : '0;
  assign bus.busy  = (state_q == GRANT) || (state_q == HOLD);
  assign bus.owner = owner_q;

`ifdef REQ_GNT_SCHED_ERR_EN
  logic stray;

  // A stray request is any req bit other than the owner's while an offer is open.
  assign stray = (state_q == OFFER) && ((bus.req & ~owner_oh) != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (stray) begin
      err <= 1'b1;
      if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_req_gnt_sched.sv
// tb/tb_req_gnt_sched.sv - self-checking bench for req_gnt_sched
//
// Purpose: directed scenarios plus randomized traffic on a 4-requester
// instance checked against a timeline reference model, and a 3-requester
// HOLD_CYCLES=1 instance for the non-power-of-two wrap.
// Build option: REQ_GNT_SCHED_ERR_EN also checks err/err_cnt.

module tb_req_gnt_sched;

  localparam int HOLD_A = 2;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  always #5 clk = ~clk;

  req_gnt_sched_if #(.NUM_REQ(4)) bus_a ();
  req_gnt_sched_if #(.NUM_REQ(3)) bus_b ();

`ifdef REQ_GNT_SCHED_ERR_EN
  logic       err_a;
  logic [7:0] err_cnt_a;
  logic       err_b;
  logic [7:0] err_cnt_b;
`endif

  req_gnt_sched #(.NUM_REQ(4), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk     (clk),
    .reset   (reset_a),
    .bus     (bus_a)
`ifdef REQ_GNT_SCHED_ERR_EN
    ,
    .err     (err_a),
    .err_cnt (err_cnt_a)
`endif
  );

  req_gnt_sched #(.NUM_REQ(3), .HOLD_CYCLES(1)) dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .bus     (bus_b)
`ifdef REQ_GNT_SCHED_ERR_EN
    ,
    .err     (err_b),
    .err_cnt (err_cnt_b)
`endif
  );

  int compares = 0;
  int mism     = 0;

  // Timeline reference model for dut_a: which cycle the scheduler next picks,
  // whether an offer is open and to whom, and the cycle of the last grant.
  int cyc        = 0;
  int idle_at    = 0;
  int gnt_at     = -100;
  int own        = 0;
  int ptr_m      = 0;
  bit offer_open = 1'b0;
  int err_m      = 0;
  int errcnt_m   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compares++;
    assert (obs === exp_v) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input logic [3:0] w, input int p);
    for (int k = 0; k < 4; k++) begin
      if (w[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  // Drive one cycle's inputs to dut_a, advance the model, then compare at the
  // following negedge.
  task automatic step(input logic [3:0] w, input logic [3:0] r, input logic rst);
    logic [3:0] oh;
    bus_a.want = w;
    bus_a.req  = r;
    reset_a    = rst;
    if (rst) begin
      offer_open = 1'b0;
      own        = 0;
      ptr_m      = 0;
      idle_at    = cyc + 1;
      gnt_at     = -100;
      err_m      = 0;
      errcnt_m   = 0;
    end else if (offer_open) begin
      oh = 4'b0001 << own;
      if ((r & ~oh) != 4'b0000) begin
        err_m = 1;
        if (errcnt_m < 255) errcnt_m++;
      end
      if (r[own]) begin
        offer_open = 1'b0;
        gnt_at     = cyc + 1;
        idle_at    = cyc + 2 + HOLD_A;
        ptr_m      = (own + 1) % 4;
      end else if (!w[own]) begin
        offer_open = 1'b0;
        idle_at    = cyc + 1;
        ptr_m      = (own + 1) % 4;
      end
    end else if (cyc == idle_at) begin
      if (w != 4'b0000) begin
        own        = pick(w, ptr_m);
        offer_open = 1'b1;
      end else begin
        idle_at = cyc + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    oh = 4'b0001 << own;
    chk("a_slot", bus_a.slot, offer_open ? oh : 4'b0000);
    chk("a_gnt", bus_a.gnt, (cyc == gnt_at) ? oh : 4'b0000);
    chk("a_busy", bus_a.busy, (cyc >= gnt_at) && (cyc <= gnt_at + HOLD_A));
    chk("a_owner", bus_a.owner, own);
`ifdef REQ_GNT_SCHED_ERR_EN
    chk("a_err", err_a, err_m);
    chk("a_err_cnt", err_cnt_a, errcnt_m);
`endif
  endtask

  initial begin
    logic [3:0] wv;
    logic [3:0] rv;
    int         gi;
    int         gidx[$];
    int         gcyc[$];
    int         exp_ord[5];

    exp_ord = '{0, 1, 2, 3, 0};
    bus_a.want = '0;
    bus_a.req  = '0;
    bus_b.want = '0;
    bus_b.req  = '0;

    // Reset state
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    chk("rst_slot", bus_a.slot, 4'b0000);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_owner", bus_a.owner, 0);

    // Single requester
    step(4'b0100, 4'b0000, 1'b0);
    chk("single_slot", bus_a.slot, 4'b0100);
    step(4'b0100, 4'b0100, 1'b0);
    chk("single_gnt", bus_a.gnt, 4'b0100);
    chk("single_slot_drop", bus_a.slot, 4'b0000);
    step(4'b0000, 4'b0000, 1'b0);
    chk("single_hold1_gnt", bus_a.gnt, 4'b0000);
    chk("single_hold1_busy", bus_a.busy, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    chk("single_hold2_busy", bus_a.busy, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    chk("single_idle_busy", bus_a.busy, 1'b0);

    // Round-robin fairness
    step(4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 40 && gidx.size() < 5; k++) begin
      rv = offer_open ? (4'b0001 << own) : 4'b0000;
      step(4'b1111, rv, 1'b0);
      if (bus_a.gnt != 4'b0000) begin
        gi = 0;
        for (int i = 0; i < 4; i++) if (bus_a.gnt[i]) gi = i;
        gidx.push_back(gi);
        gcyc.push_back(cyc);
      end
    end
    chk("fair_count", gidx.size(), 5);
    for (int k = 0; k < gidx.size(); k++) begin
      chk("fair_order", gidx[k], exp_ord[k]);
      if (k > 0) chk("fair_spacing", gcyc[k] - gcyc[k-1], 3 + HOLD_A);
    end

    // Abandoned offer
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0011, 4'b0000, 1'b0);
    chk("aband_slot0", bus_a.slot, 4'b0001);
    step(4'b0010, 4'b0000, 1'b0);
    chk("aband_idle_slot", bus_a.slot, 4'b0000);
    chk("aband_no_gnt", bus_a.gnt, 4'b0000);
    step(4'b0010, 4'b0000, 1'b0);
    chk("aband_next_slot", bus_a.slot, 4'b0010);

    // Stray request
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0001, 4'b0000, 1'b0);
    chk("stray_slot", bus_a.slot, 4'b0001);
    step(4'b0001, 4'b1000, 1'b0);
    chk("stray_no_gnt", bus_a.gnt, 4'b0000);
    chk("stray_slot_kept", bus_a.slot, 4'b0001);
`ifdef REQ_GNT_SCHED_ERR_EN
    chk("stray_err", err_a, 1'b1);
    chk("stray_err_cnt", err_cnt_a, 8'd1);
`endif
    step(4'b0001, 4'b0001, 1'b0);
    chk("stray_then_gnt", bus_a.gnt, 4'b0001);
    repeat (3) step(4'b0000, 4'b0000, 1'b0);

    // Reset mid-GRANT
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0110, 4'b0000, 1'b0);
    step(4'b0110, 4'b0010, 1'b0);
    chk("rgnt_gnt", bus_a.gnt, 4'b0010);
    step(4'b0110, 4'b0000, 1'b1);
    chk("rgnt_gnt_cut", bus_a.gnt, 4'b0000);
    chk("rgnt_busy", bus_a.busy, 1'b0);
    chk("rgnt_slot", bus_a.slot, 4'b0000);
    chk("rgnt_owner", bus_a.owner, 0);
    step(4'b0110, 4'b0000, 1'b0);
    chk("rgnt_first_offer", bus_a.slot, 4'b0010);

    // Randomized traffic against the model
    wv = 4'b1111;
    for (int k = 0; k < 600; k++) begin
      rv = 4'b0000;
      if ($urandom_range(0, 3) == 0) begin
        gi = $urandom_range(0, 3);
        wv[gi] = ~wv[gi];
      end
      if (offer_open) begin
        case ($urandom_range(0, 5))
          0, 1: rv[own] = 1'b1;
          2:    wv[own] = 1'b0;
          default: ;
        endcase
      end
      if ($urandom_range(0, 9) == 0) rv[$urandom_range(0, 3)] = 1'b1;
      step(wv, rv, ($urandom_range(0, 99) == 0));
    end

    // Non-power-of-two wrap on the 3-requester, single-HOLD instance
    step(4'b0000, 4'b0000, 1'b1);
    reset_b = 1'b0;
    step(4'b0000, 4'b0000, 1'b0);
    chk("b_rst_slot", bus_b.slot, 3'b000);
    bus_b.want = 3'b100;
    step(4'b0000, 4'b0000, 1'b0);
    chk("b_slot2", bus_b.slot, 3'b100);
    bus_b.req = 3'b100;
    step(4'b0000, 4'b0000, 1'b0);
    chk("b_gnt2", bus_b.gnt, 3'b100);
    chk("b_owner2", bus_b.owner, 2);
    bus_b.req  = 3'b000;
    bus_b.want = 3'b001;
    step(4'b0000, 4'b0000, 1'b0);
    chk("b_hold_gnt", bus_b.gnt, 3'b000);
    chk("b_hold_busy", bus_b.busy, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    chk("b_idle_busy", bus_b.busy, 1'b0);
    chk("b_idle_slot", bus_b.slot, 3'b000);
    step(4'b0000, 4'b0000, 1'b0);
    chk("b_wrap_slot", bus_b.slot, 3'b001);
    chk("b_wrap_owner", bus_b.owner, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

endmodule
